mac_layer_ctrl: RTL and testbench

Sequencer for the 64-lane Q8.8 `mac` datapath; runs one fully-connected layer.
- Per output neuron: clears the MAC accumulator, then streams `cfg_chunks` 64-element data/weight chunks from external buffers.
- After the last chunk it captures the MAC `result`, applies optional ReLU, and emits one word per neuron on a valid/ready port.
- Sits between the layer buffers (data RAM, weight RAM) and the writeback path.

---
 rtl/mac_ctrl_pkg.sv | 26 ++
 rtl/mac_addr_gen.sv | 42 ++++
 rtl/mac_layer_ctrl.sv | 130 +++++++++++++
 tb/tb_mac_layer_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// mac_ctrl_pkg : shared types/constants for the MAC layer sequencer
// Rev 1.0
// ---------------------------------------------------------------
package mac_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ACC  = 3'd1,
    ST_WAIT = 3'd2,
    ST_CAPT = 3'd3,
    ST_OUT  = 3'd4,
    ST_FIN  = 3'd5
  } state_t;

  localparam int          FRAC_BITS = 8;
  localparam logic [15:0] QZERO     = 16'h0000;
  localparam int          LANES     = 64;

  function automatic logic [15:0] relu_q88(input logic [15:0] value, input logic enable);
    return (enable && value[15]) ? QZERO : value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mac_addr_gen.sv
`default_nettype none
// ---------------------------------------------------------------
// mac_addr_gen : chunk/neuron counters and running weight address
// Rev 1.0
// ---------------------------------------------------------------
module mac_addr_gen #(
  parameter int CHUNK_W  = 6,
  parameter int NEURON_W = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        chunk_step,
  input  logic                        neuron_step,
  input  logic [CHUNK_W-1:0]          num_chunks,
  output logic [CHUNK_W-1:0]          chunk,
  output logic [NEURON_W-1:0]         neuron,
  output logic [NEURON_W+CHUNK_W-1:0] weight_addr,
  output logic                        last_chunk
);

  assign last_chunk = (chunk == num_chunks - CHUNK_W'(1));

  // weight_addr never rewinds: after neuron n it already sits at (n+1)*chunks
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      chunk       <= '0;
      neuron      <= '0;
      weight_addr <= '0;
    end else begin
      if (chunk_step) begin
        chunk       <= last_chunk ? '0 : chunk + CHUNK_W'(1);
        weight_addr <= weight_addr + (NEURON_W+CHUNK_W)'(1);
      end
      if (neuron_step) begin
        neuron <= neuron + NEURON_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mac_layer_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------
// mac_layer_ctrl : sequences one fully-connected layer on the MAC
// Rev 1.0
// ---------------------------------------------------------------
module mac_layer_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int CHUNK_W  = 6,
  parameter int NEURON_W = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [CHUNK_W-1:0]          cfg_chunks,
  input  logic [NEURON_W-1:0]         cfg_neurons,
  input  logic                        cfg_relu,
  output logic                        busy,
  output logic                        done,
  output logic                        rd_en,
  output logic [CHUNK_W-1:0]          data_addr,
  output logic [NEURON_W+CHUNK_W-1:0] weight_addr,
  output logic                        mac_reset,
  output logic                        mac_gate,
  input  logic [15:0]                 mac_result,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [15:0]                 out_data,
  output logic [NEURON_W-1:0]         out_index
);

  state_t               state_q, state_d;
  logic [CHUNK_W-1:0]   chunks_q;
  logic [NEURON_W-1:0]  neurons_q;
  logic                 relu_q;
  logic                 launch;
  logic                 chunk_step;
  logic                 neuron_step;
  logic                 last_chunk;
  logic                 last_neuron;
  logic [CHUNK_W-1:0]   chunk;
  logic [NEURON_W-1:0]  neuron;

  assign launch      = (state_q == ST_IDLE) && start;
  assign chunk_step  = (state_q == ST_ACC);
  assign neuron_step = (state_q == ST_OUT) && out_ready;
  assign last_neuron = (neuron == neurons_q - NEURON_W'(1));
  assign data_addr   = chunk;

  mac_addr_gen #(
    .CHUNK_W  (CHUNK_W),
    .NEURON_W (NEURON_W)
  ) u_addr_gen (
    .clk         (clk),
    .reset       (reset),
    .clear       (launch),
    .chunk_step  (chunk_step),
    .neuron_step (neuron_step),
    .num_chunks  (chunks_q),
    .chunk       (chunk),
    .neuron      (neuron),
    .weight_addr (weight_addr),
    .last_chunk  (last_chunk)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (cfg_chunks != '0 && cfg_neurons != '0) ? ST_ACC : ST_FIN;
        end
      end
      ST_ACC:  if (last_chunk) state_d = ST_WAIT;
      ST_WAIT: state_d = ST_CAPT;
      ST_CAPT: state_d = ST_OUT;
      ST_OUT:  if (out_ready) state_d = last_neuron ? ST_FIN : ST_ACC;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_FIN);
    rd_en     = (state_q == ST_ACC);
    out_valid = (state_q == ST_OUT);
    mac_reset = reset || ((state_q == ST_ACC) && (chunk == '0));
  end

  // Operands arrive one cycle after the read strobe; outside that window the
  // external gate zeroes them so the accumulator simply holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      mac_gate <= 1'b0;
    end else begin
      mac_gate <= rd_en;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chunks_q  <= '0;
      neurons_q <= '0;
      relu_q    <= 1'b0;
      out_data  <= QZERO;
      out_index <= '0;
    end else begin
      if (launch) begin
        chunks_q  <= cfg_chunks;
        neurons_q <= cfg_neurons;
        relu_q    <= cfg_relu;
      end
      if (state_q == ST_CAPT) begin
        out_data  <= relu_q88(mac_result, relu_q);
        out_index <= neuron;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_layer_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------
// tb_mac_layer_ctrl : randomized self-checking bench with MAC/buffer model
// Rev 1.0
// ---------------------------------------------------------------
module tb_mac_layer_ctrl;

  localparam int CW = 6;
  localparam int NW = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [CW-1:0]  cfg_chunks;
  logic [NW-1:0]  cfg_neurons;
  logic           cfg_relu;
  logic           busy, done, rd_en, mac_reset, mac_gate, out_valid;
  logic           out_ready;
  logic [CW-1:0]  data_addr;
  logic [NW+CW-1:0] weight_addr;
  logic [15:0]    mac_result;
  logic [15:0]    out_data;
  logic [NW-1:0]  out_index;

  mac_layer_ctrl #(.CHUNK_W(CW), .NEURON_W(NW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .cfg_chunks  (cfg_chunks),
    .cfg_neurons (cfg_neurons),
    .cfg_relu    (cfg_relu),
    .busy        (busy),
    .done        (done),
    .rd_en       (rd_en),
    .data_addr   (data_addr),
    .weight_addr (weight_addr),
    .mac_reset   (mac_reset),
    .mac_gate    (mac_gate),
    .mac_result  (mac_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_index   (out_index)
  );

  always #5 clk = ~clk;

  // Layer buffers and a behavioural 64-lane Q8.8 MAC driven by the DUT strobes
  shortint data_mem   [64][64];
  shortint weight_mem [256][64];
  longint  acc;
  int      rd_d, rd_w;

  function automatic longint dot(input int d, input int w);
    longint s = 0;
    for (int l = 0; l < 64; l++) s += longint'(data_mem[d][l]) * longint'(weight_mem[w][l]);
    return s;
  endfunction

  always @(posedge clk) begin
    if (mac_reset)     acc <= 0;
    else if (mac_gate) acc <= acc + dot(rd_d, rd_w);
    if (rd_en) begin
      rd_d <= int'(data_addr);
      rd_w <= int'(weight_addr);
    end
  end
  assign mac_result = acc[23:8];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [15:0] exp_q[$];

  function automatic shortint rnd_q88();
    int v = int'($urandom_range(0, 2047)) - 1024;
    return shortint'(v);
  endfunction

  // Expected neuron outputs straight from the layer definition
  task automatic prepare(input int n_ch, input int n_nr, input bit relu, input int mode);
    longint s;
    logic [15:0] r;
    exp_q.delete();
    for (int c = 0; c < n_ch; c++)
      for (int l = 0; l < 64; l++)
        data_mem[c][l] = (mode == 0) ? rnd_q88() : (mode == 1) ? 16'h0100 : 16'h0080;
    for (int n = 0; n < n_nr; n++)
      for (int c = 0; c < n_ch; c++)
        for (int l = 0; l < 64; l++)
          weight_mem[n*n_ch+c][l] = (mode == 0) ? rnd_q88() :
                                    (mode == 1 || n == 0) ? 16'h0100 : 16'hFF00;
    if (n_ch != 0) begin
      for (int n = 0; n < n_nr; n++) begin
        s = 0;
        for (int c = 0; c < n_ch; c++)
          for (int l = 0; l < 64; l++)
            s += longint'(data_mem[c][l]) * longint'(weight_mem[n*n_ch+c][l]);
        r = s[23:8];
        if (relu && r[15]) r = 16'h0000;
        exp_q.push_back(r);
      end
    end
  endtask

  task automatic run_layer(input int n_ch, input int n_nr, input bit relu, input int mode,
                           input bit noisy_start);
    int cyc, stalls, reads, exp_w, exp_c, exp_idx, exp_done;
    bit hold, next_pending;
    logic [15:0] held_data;
    logic [NW-1:0] held_idx;
    prepare(n_ch, n_nr, relu, mode);
    @(negedge clk);
    cfg_chunks  = CW'(n_ch);
    cfg_neurons = NW'(n_nr);
    cfg_relu    = relu;
    start       = 1'b1;
    out_ready   = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_chunks  = CW'($urandom);
    cfg_neurons = NW'($urandom);
    cfg_relu    = 1'($urandom);
    cyc = 1; stalls = 0; reads = 0; exp_w = 0; exp_c = 0; exp_idx = 0;
    hold = 0; next_pending = 0; held_data = '0; held_idx = '0;
    forever begin
      out_ready = ($urandom_range(0, 3) != 0);
      start     = noisy_start && ($urandom_range(0, 4) == 0);
      #1;
      check("busy", busy, 1'b1);
      if (next_pending) begin
        check("next_start", rd_en, 1'b1);
        next_pending = 0;
      end
      if (hold) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", out_data, held_data);
        check("hold_index", out_index, held_idx);
      end
      if (rd_en) begin
        check("data_addr", data_addr, exp_c);
        check("weight_addr", weight_addr, exp_w);
        check("mac_reset_c", mac_reset, exp_c == 0);
        exp_w++;
        exp_c = (exp_c + 1) % n_ch;
        reads++;
      end
      if (out_valid) begin
        check("gate_in_out", mac_gate, 1'b0);
        if (out_ready) begin
          if (exp_q.size() == 0) check("extra_output", 1, 0);
          else begin
            check("out_data", out_data, exp_q.pop_front());
            check("out_index", out_index, exp_idx);
          end
          exp_idx++;
          next_pending = (exp_idx < n_nr);
        end else stalls++;
      end
      hold = out_valid && !out_ready;
      held_data = out_data;
      held_idx  = out_index;
      if (done) begin
        exp_done = (n_ch == 0 || n_nr == 0) ? 1 : n_nr * (n_ch + 3) + 1 + stalls;
        check("done_cycle", cyc, exp_done);
        break;
      end
      if (cyc > 4000) begin
        check("timeout", 0, 1);
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b0;
    check("reads", reads, (n_ch == 0 || n_nr == 0) ? 0 : n_ch * n_nr);
    check("left", exp_q.size(), 0);
    @(posedge clk); #1;
    check("idle_busy", busy, 1'b0);
    check("idle_done", done, 1'b0);
  endtask

  task automatic reset_mid_acc();
    int guard = 0;
    bit saw_done = 0;
    prepare(4, 2, 1'b0, 0);
    @(negedge clk);
    cfg_chunks = CW'(4); cfg_neurons = NW'(2); cfg_relu = 1'b0;
    start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!(rd_en && data_addr == CW'(1)) && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("reach_c1", guard < 20, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_busy", busy, 1'b0);
    check("rst_rd_en", rd_en, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_mac_reset", mac_reset, 1'b1);
    check("rst_gate", mac_gate, 1'b0);
    check("rst_waddr", weight_addr, 0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1;
    end
    check("rst_no_done", saw_done, 1'b0);
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    cfg_chunks = '0; cfg_neurons = '0; cfg_relu = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("r_busy", busy, 1'b0);
    check("r_done", done, 1'b0);
    check("r_rd_en", rd_en, 1'b0);
    check("r_gate", mac_gate, 1'b0);
    check("r_valid", out_valid, 1'b0);
    check("r_data", out_data, 16'h0000);
    check("r_index", out_index, 0);
    check("r_daddr", data_addr, 0);
    check("r_waddr", weight_addr, 0);
    check("r_mac_reset", mac_reset, 1'b1);
    @(negedge clk);
    reset = 1'b0;

    run_layer(1, 1, 1'b0, 1, 1'b0);
    run_layer(2, 2, 1'b1, 2, 1'b0);
    run_layer(0, 3, 1'b0, 0, 1'b0);
    run_layer(3, 0, 1'b0, 0, 1'b0);
    reset_mid_acc();
    run_layer(4, 2, 1'b0, 0, 1'b0);
    for (int i = 0; i < 8; i++)
      run_layer($urandom_range(1, 5), $urandom_range(1, 5), 1'($urandom), 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
